// File: rtl/msx_mapper_pkg.sv
// msx_mapper_pkg: FSM states and reset constants shared by the mapper front end
package msx_mapper_pkg;
  typedef enum logic [2:0] {IDLE, IO_WR, IO_RD, MEM_REQ, MEM_WAIT, HOLD} state_t;
  localparam logic [7:0] MAPPER_PORT_BASE = 8'hFC;
  localparam logic [3:0][7:0] SEG_RESET = {8'h00, 8'h01, 8'h02, 8'h03};
  function automatic logic [7:0] seg_mask(int bits);
    return 8'((16'd1 << bits) - 16'd1);
  endfunction
endpackage

// File: rtl/msx_mapper_bus_fsm_if.sv
// msx_mapper_bus_fsm_if: MSX slot bus plus PSRAM request channel
interface msx_mapper_bus_fsm_if #(parameter int SEG_BITS = 8);
  logic ex_bus_sltsl_n, ex_bus_mreq_n, ex_bus_iorq_n, ex_bus_rd_n, ex_bus_wr_n;
  logic [15:0] ex_bus_addr;
  logic [7:0] ex_bus_data_in, bus_data_out;
  logic bus_data_reverse;
  logic [SEG_BITS+13:0] psram_addr;
  logic [7:0] psram_din, psram_dout;
  logic psram_read, psram_write, psram_busy;
  modport slave (
    input ex_bus_sltsl_n, ex_bus_mreq_n, ex_bus_iorq_n, ex_bus_rd_n, ex_bus_wr_n,
    input ex_bus_addr, ex_bus_data_in, psram_busy, psram_dout,
    output bus_data_out, bus_data_reverse, psram_addr, psram_din, psram_read, psram_write
  );
  modport master (
    output ex_bus_sltsl_n, ex_bus_mreq_n, ex_bus_iorq_n, ex_bus_rd_n, ex_bus_wr_n,
    output ex_bus_addr, ex_bus_data_in, psram_busy, psram_dout,
    input bus_data_out, bus_data_reverse, psram_addr, psram_din, psram_read, psram_write
  );
endinterface

// File: rtl/msx_bus_sync.sv
// msx_bus_sync: 2-FF synchronisers for the slot strobes with cycle start/release detect
module msx_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] strobe_n,
  output logic       sltsl,
  output logic       mreq,
  output logic       iorq,
  output logic       rd,
  output logic       wr,
  output logic       start,
  output logic       released
);
  logic [4:0] s1, s2;
  logic act_q;
  // synchronise active-low strobes and remember last rd|wr for edge detect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      act_q <= 1'b0;
    end else begin
      s1 <= strobe_n;
      s2 <= s1;
      act_q <= rd | wr;
    end
  assign {sltsl, mreq, iorq, rd, wr} = ~s2;
  assign start = (rd | wr) & ~act_q;
  assign released = ~rd & ~wr;
endmodule

// File: rtl/msx_mapper_bus_fsm.sv
// msx_mapper_bus_fsm: MSX mapper registers and slot-to-PSRAM cycle translator
module msx_mapper_bus_fsm
  import msx_mapper_pkg::*;
#(
  parameter int SEG_BITS = 8,
  parameter int TIMEOUT  = 64,
  parameter bit READBACK = 1'b1
) (
  input  logic                 clk_72m,
  input  logic                 bus_reset_n,
  msx_mapper_bus_fsm_if.slave  bus,
  output logic [7:0]           mapper_reg0,
  output logic [7:0]           mapper_reg1,
  output logic [7:0]           mapper_reg2,
  output logic [7:0]           mapper_reg3,
  output logic                 mapper_read,
  output logic                 mapper_write,
  input  logic                 check_clear,
  output logic [7:0]           check_fsm_counter_max
);
  localparam logic [7:0] MASK = seg_mask(SEG_BITS);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic sltsl, mreq, iorq, rd, wr, start, released;
  logic [7:0] seg [4];
  logic [1:0] port_q;
  logic [7:0] data_q, occ, occ_nx;
  logic is_wr, rev_q, io_hit, is_io, is_mem, timer_done;
  logic [TW-1:0] timer;
  msx_bus_sync u_sync (
    .clk(clk_72m), .rst_n(bus_reset_n),
    .strobe_n({bus.ex_bus_sltsl_n, bus.ex_bus_mreq_n, bus.ex_bus_iorq_n, bus.ex_bus_rd_n, bus.ex_bus_wr_n}),
    .sltsl(sltsl), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .start(start), .released(released)
  );
  assign io_hit = bus.ex_bus_addr[7:2] == MAPPER_PORT_BASE[7:2];
  assign is_io = iorq & ~mreq;
  assign is_mem = mreq & ~iorq & sltsl;
  assign timer_done = timer == TW'(TIMEOUT - 1);
  assign occ_nx = state == IDLE ? 8'd1 : occ == 8'hFF ? occ : occ + 8'd1;
  assign {mapper_reg0, mapper_reg1, mapper_reg2, mapper_reg3} = {seg[0], seg[1], seg[2], seg[3]};
  assign mapper_write = state == IO_WR;
  assign mapper_read = state == IO_RD;
  // gating with the synchronised strobe drops the bus driver the cycle rd_n is seen released
  assign bus.bus_data_reverse = rev_q & rd;
  // next-state decode; conflicting or foreign cycles park in HOLD untouched
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = (is_io && wr && io_hit) ? IO_WR :
                                      (is_io && rd && io_hit && READBACK) ? IO_RD :
                                      is_mem ? MEM_REQ : HOLD;
      IO_WR,
      IO_RD:    state_nx = HOLD;
      MEM_REQ:  state_nx = bus.psram_busy ? MEM_WAIT : timer_done ? HOLD : MEM_REQ;
      MEM_WAIT: state_nx = (!bus.psram_busy || timer_done) ? HOLD : MEM_WAIT;
      default:  state_nx = released ? IDLE : HOLD;
    endcase
  end
  // state, mapper registers, PSRAM request and bus return path
  always_ff @(posedge clk_72m or negedge bus_reset_n)
    if (!bus_reset_n) begin
      state <= IDLE;
      for (int i = 0; i < 4; i++) seg[i] <= SEG_RESET[i] & MASK;
      port_q <= '0;
      data_q <= '0;
      is_wr <= 1'b0;
      rev_q <= 1'b0;
      timer <= '0;
      occ <= '0;
      check_fsm_counter_max <= '0;
      bus.bus_data_out <= '0;
      bus.psram_addr <= '0;
      bus.psram_din <= '0;
      bus.psram_read <= 1'b0;
      bus.psram_write <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= state_nx != state ? '0 : timer + 1'b1;
      occ <= occ_nx;
      if (check_clear) check_fsm_counter_max <= '0;
      else if (state_nx == HOLD && state != HOLD && occ_nx > check_fsm_counter_max) check_fsm_counter_max <= occ_nx;
      if (state == IDLE && start) begin
        port_q <= bus.ex_bus_addr[1:0];
        data_q <= bus.ex_bus_data_in;
        is_wr <= wr;
      end
      if (state == IDLE && state_nx == MEM_REQ) begin
        bus.psram_addr <= {seg[bus.ex_bus_addr[15:14]][SEG_BITS-1:0], bus.ex_bus_addr[13:0]};
        bus.psram_din <= bus.ex_bus_data_in;
        bus.psram_read <= ~wr;
        bus.psram_write <= wr;
      end
      if (state == MEM_REQ && state_nx != MEM_REQ) begin
        bus.psram_read <= 1'b0;
        bus.psram_write <= 1'b0;
      end
      if (state == MEM_WAIT && !bus.psram_busy && !is_wr) begin
        bus.bus_data_out <= bus.psram_dout;
        rev_q <= rd;
      end
      if (state == IO_WR) seg[port_q] <= data_q & MASK;
      if (state == IO_RD) begin
        bus.bus_data_out <= seg[port_q];
        rev_q <= 1'b1;
      end
      if (state == HOLD && released) rev_q <= 1'b0;
    end
endmodule

// File: tb/tb_msx_mapper_bus_fsm.sv
// tb_msx_mapper_bus_fsm: scoreboard bench for the MSX mapper front end
`timescale 1ns/1ps
module tb_msx_mapper_bus_fsm;
  import msx_mapper_pkg::*;
  typedef struct { logic [21:0] addr; logic [7:0] din; logic wr; } req_t;
  logic clk_72m = 1'b0, bus_reset_n = 1'b0, check_clear = 1'b0;
  logic [7:0] r0, r1, r2, r3, cmax;
  logic mapper_read, mapper_write, req_q = 1'b0;
  int n_checks = 0, n_fail = 0, n_wr_pulse = 0, n_rd_pulse = 0, n_req = 0, n_rev = 0;
  req_t exp_req_q[$];
  logic [7:0] exp_bus_q[$];
  msx_mapper_bus_fsm_if #(.SEG_BITS(8)) bus ();
  msx_mapper_bus_fsm #(.SEG_BITS(8), .TIMEOUT(64), .READBACK(1'b1)) dut (
    .clk_72m(clk_72m), .bus_reset_n(bus_reset_n), .bus(bus),
    .mapper_reg0(r0), .mapper_reg1(r1), .mapper_reg2(r2), .mapper_reg3(r3),
    .mapper_read(mapper_read), .mapper_write(mapper_write),
    .check_clear(check_clear), .check_fsm_counter_max(cmax)
  );
  always #7 clk_72m = ~clk_72m;
  // pulse and request event counters sampled on the falling edge
  always @(negedge clk_72m) begin
    n_wr_pulse += int'(mapper_write);
    n_rd_pulse += int'(mapper_read);
    n_rev += int'(bus.bus_data_reverse);
    if ((bus.psram_read || bus.psram_write) && !req_q) n_req++;
    req_q = bus.psram_read || bus.psram_write;
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk_72m);
  endtask
  task automatic bus_start(logic [15:0] a, logic [7:0] d, logic io, logic mem, logic w);
    bus.ex_bus_addr = a;
    bus.ex_bus_data_in = d;
    bus.ex_bus_iorq_n = ~io;
    bus.ex_bus_mreq_n = ~mem;
    bus.ex_bus_sltsl_n = ~mem;
    bus.ex_bus_rd_n = w;
    bus.ex_bus_wr_n = ~w;
  endtask
  task automatic bus_end();
    {bus.ex_bus_sltsl_n, bus.ex_bus_mreq_n, bus.ex_bus_iorq_n, bus.ex_bus_rd_n, bus.ex_bus_wr_n} = '1;
    cyc(5);
  endtask
  task automatic psram_serve(int busy_cycles, logic [7:0] dout);
    req_t e;
    int k = 0;
    while (!(bus.psram_read || bus.psram_write) && k < 20) begin cyc(1); k++; end
    e = exp_req_q.pop_front();
    n_checks++;
    if (!(bus.psram_read || bus.psram_write)) begin
      n_fail++;
      $display("FAIL psram_req: no request in 20 cycles, expected addr %h", e.addr);
    end else if (bus.psram_addr !== e.addr || bus.psram_write !== e.wr || bus.psram_read !== ~e.wr || (e.wr && bus.psram_din !== e.din)) begin
      n_fail++;
      $display("FAIL psram_req: got addr %h wr %b rd %b din %h, expected addr %h wr %b din %h",
               bus.psram_addr, bus.psram_write, bus.psram_read, bus.psram_din, e.addr, e.wr, e.din);
    end
    if (busy_cycles > 0) begin
      bus.psram_busy = 1'b1;
      cyc(1);
      n_checks++;
      if (bus.psram_read || bus.psram_write) begin
        n_fail++;
        $display("FAIL psram_drop: rd %b wr %b one cycle after busy, expected 0 0", bus.psram_read, bus.psram_write);
      end
      cyc(busy_cycles - 1);
      bus.psram_dout = dout;
      bus.psram_busy = 1'b0;
    end
  endtask
  task automatic test_reset();
    bus_reset_n = 1'b0;
    cyc(3);
    bus_reset_n = 1'b1;
    cyc(2);
    n_checks++;
    if ({r0, r1, r2, r3} !== 32'h03020100) begin n_fail++; $display("FAIL reset_regs: got %h, expected 03020100", {r0, r1, r2, r3}); end
    n_checks++;
    if ({bus.psram_read, bus.psram_write, bus.bus_data_reverse, mapper_read, mapper_write} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, expected 00000", {bus.psram_read, bus.psram_write, bus.bus_data_reverse, mapper_read, mapper_write});
    end
    n_checks++;
    if ({bus.psram_addr, bus.psram_din, bus.bus_data_out} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h din %h dout %h, expected all 0", bus.psram_addr, bus.psram_din, bus.bus_data_out);
    end
    n_checks++;
    if (cmax !== 8'h00) begin n_fail++; $display("FAIL reset_cmax: got %h, expected 00", cmax); end
  endtask
  task automatic test_io_write();
    int w0 = n_wr_pulse, q0 = n_req;
    bus_start(16'h00FE, 8'h5A, 1'b1, 1'b0, 1'b1);
    cyc(8);
    n_checks++;
    if (n_wr_pulse - w0 != 1) begin n_fail++; $display("FAIL io_wr_pulse: got %0d high cycles, expected 1", n_wr_pulse - w0); end
    n_checks++;
    if ({r0, r1, r2, r3} !== 32'h03025A00) begin n_fail++; $display("FAIL io_wr_regs: got %h, expected 03025a00", {r0, r1, r2, r3}); end
    n_checks++;
    if (n_req != q0) begin n_fail++; $display("FAIL io_wr_psram: got %0d requests, expected 0", n_req - q0); end
    bus_end();
  endtask
  task automatic test_io_read();
    int p0 = n_rd_pulse, k = 0;
    exp_bus_q.push_back(8'h5A);
    bus_start(16'h33FE, 8'h00, 1'b1, 1'b0, 1'b0);
    while (!bus.bus_data_reverse && k < 10) begin cyc(1); k++; end
    n_checks++;
    if (!bus.bus_data_reverse || bus.bus_data_out !== exp_bus_q[0]) begin
      n_fail++;
      $display("FAIL io_rd_data: got rev %b data %h, expected rev 1 data %h", bus.bus_data_reverse, bus.bus_data_out, exp_bus_q[0]);
    end
    void'(exp_bus_q.pop_front());
    cyc(2);
    n_checks++;
    if (n_rd_pulse - p0 != 1) begin n_fail++; $display("FAIL io_rd_pulse: got %0d high cycles, expected 1", n_rd_pulse - p0); end
    bus_end();
    n_checks++;
    if (bus.bus_data_reverse !== 1'b0) begin n_fail++; $display("FAIL io_rd_release: got rev %b, expected 0", bus.bus_data_reverse); end
  endtask
  task automatic test_mem_read();
    int k = 0;
    bus_start(16'h00FD, 8'h12, 1'b1, 1'b0, 1'b1);
    cyc(6);
    bus_end();
    n_checks++;
    if (r1 !== 8'h12) begin n_fail++; $display("FAIL mem_rd_setup: got reg1 %h, expected 12", r1); end
    exp_req_q.push_back('{addr: 22'h048567, din: 8'h00, wr: 1'b0});
    exp_bus_q.push_back(8'hC3);
    bus_start(16'h4567, 8'h00, 1'b0, 1'b1, 1'b0);
    psram_serve(6, 8'hC3);
    while (!bus.bus_data_reverse && k < 10) begin cyc(1); k++; end
    n_checks++;
    if (!bus.bus_data_reverse || bus.bus_data_out !== exp_bus_q[0]) begin
      n_fail++;
      $display("FAIL mem_rd_data: got rev %b data %h, expected rev 1 data %h", bus.bus_data_reverse, bus.bus_data_out, exp_bus_q[0]);
    end
    void'(exp_bus_q.pop_front());
    cyc(3);
    n_checks++;
    if (bus.bus_data_reverse !== 1'b1) begin n_fail++; $display("FAIL mem_rd_hold: got rev %b while rd active, expected 1", bus.bus_data_reverse); end
    {bus.ex_bus_sltsl_n, bus.ex_bus_mreq_n, bus.ex_bus_rd_n} = 3'b111;
    k = 0;
    while (bus.bus_data_reverse && k < 6) begin cyc(1); k++; end
    n_checks++;
    if (bus.bus_data_reverse !== 1'b0) begin n_fail++; $display("FAIL mem_rd_release: got rev %b after rd release, expected 0", bus.bus_data_reverse); end
    cyc(4);
  endtask
  task automatic test_mem_write();
    int v0;
    exp_req_q.push_back('{addr: 22'h000000, din: 8'h77, wr: 1'b1});
    v0 = n_rev;
    bus_start(16'hC000, 8'h77, 1'b0, 1'b1, 1'b1);
    psram_serve(3, 8'hEE);
    cyc(6);
    n_checks++;
    if (n_rev != v0) begin n_fail++; $display("FAIL mem_wr_rev: got %0d reverse cycles, expected 0", n_rev - v0); end
    n_checks++;
    if (bus.bus_data_out !== 8'hC3) begin n_fail++; $display("FAIL mem_wr_dout: got %h, expected c3 untouched", bus.bus_data_out); end
    bus_end();
  endtask
  task automatic test_timeout();
    int len = 0;
    check_clear = 1'b1;
    cyc(1);
    check_clear = 1'b0;
    cyc(1);
    n_checks++;
    if (cmax !== 8'h00) begin n_fail++; $display("FAIL cmax_clear: got %h, expected 00", cmax); end
    exp_req_q.push_back('{addr: 22'h00C000, din: 8'h00, wr: 1'b0});
    bus_start(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
    psram_serve(0, 8'h00);
    while ((bus.psram_read || bus.psram_write) && len < 100) begin len++; cyc(1); end
    n_checks++;
    if (len != 64) begin n_fail++; $display("FAIL timeout_len: request held %0d cycles, expected 64", len); end
    cyc(1);
    n_checks++;
    if (bus.bus_data_reverse !== 1'b0) begin n_fail++; $display("FAIL timeout_rev: got %b, expected 0", bus.bus_data_reverse); end
    n_checks++;
    if (cmax !== 8'h41) begin n_fail++; $display("FAIL timeout_cmax: got %h, expected 41", cmax); end
    bus_end();
    n_checks++;
    if (dut.state !== IDLE) begin n_fail++; $display("FAIL timeout_idle: got state %0d, expected IDLE", dut.state); end
  endtask
  task automatic test_conflict_and_reset();
    int q0 = n_req, w0 = n_wr_pulse;
    bus_start(16'h00FC, 8'h99, 1'b1, 1'b1, 1'b1);
    cyc(10);
    n_checks++;
    if (n_req != q0 || n_wr_pulse != w0) begin
      n_fail++;
      $display("FAIL conflict_side: got %0d requests %0d writes, expected 0 0", n_req - q0, n_wr_pulse - w0);
    end
    n_checks++;
    if (r0 !== 8'h03) begin n_fail++; $display("FAIL conflict_reg: got reg0 %h, expected 03", r0); end
    bus_end();
    exp_req_q.push_back('{addr: 22'h168000, din: 8'h11, wr: 1'b1});
    bus_start(16'h8000, 8'h11, 1'b0, 1'b1, 1'b1);
    psram_serve(0, 8'h00);
    bus.psram_busy = 1'b1;
    cyc(3);
    bus_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({r0, r1, r2, r3} !== 32'h03020100) begin n_fail++; $display("FAIL rst_mid_regs: got %h, expected 03020100", {r0, r1, r2, r3}); end
    n_checks++;
    if ({bus.psram_read, bus.psram_write, bus.bus_data_reverse, mapper_read, mapper_write} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_strobes: got %b, expected 00000", {bus.psram_read, bus.psram_write, bus.bus_data_reverse, mapper_read, mapper_write});
    end
    n_checks++;
    if ({bus.psram_addr, bus.psram_din, bus.bus_data_out} !== 38'h0) begin
      n_fail++;
      $display("FAIL rst_mid_data: got addr %h din %h dout %h, expected all 0", bus.psram_addr, bus.psram_din, bus.bus_data_out);
    end
    n_checks++;
    if (cmax !== 8'h00) begin n_fail++; $display("FAIL rst_mid_cmax: got %h, expected 00", cmax); end
    bus.psram_busy = 1'b0;
    {bus.ex_bus_sltsl_n, bus.ex_bus_mreq_n, bus.ex_bus_iorq_n, bus.ex_bus_rd_n, bus.ex_bus_wr_n} = '1;
    cyc(2);
    bus_reset_n = 1'b1;
    cyc(3);
  endtask
  initial begin
    {bus.ex_bus_sltsl_n, bus.ex_bus_mreq_n, bus.ex_bus_iorq_n, bus.ex_bus_rd_n, bus.ex_bus_wr_n} = '1;
    bus.ex_bus_addr = '0;
    bus.ex_bus_data_in = '0;
    bus.psram_busy = 1'b0;
    bus.psram_dout = '0;
    test_reset();
    test_io_write();
    test_io_read();
    test_mem_read();
    test_mem_write();
    test_timeout();
    test_conflict_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog expired");
  end
endmodule
